// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state, condition and timeout definitions for the hazard sequencer
package hazard_pkg;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} hc_state_t;

    localparam int TMO_W = 16;

    // Encoded so that a larger value means a higher-priority condition.
    typedef enum logic [1:0] {COND_NONE, COND_BR, COND_LU, COND_MW} hc_cond_t;

    function automatic hc_cond_t hcArbitrate(input logic mw, input logic lu, input logic br);
        hc_cond_t res;
        if (mw)
            res = COND_MW;
        else if (lu)
            res = COND_LU;
        else if (br)
            res = COND_BR;
        else
            res = COND_NONE;
        return res;
    endfunction

endpackage

// File: rtl/hc_sat_counter.sv
// rtl/hc_sat_counter.sv - saturating event counter, holds at all-ones
module hc_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt_o <= '0;
        else if (inc_i && (cnt_o != '1))
            cnt_o <= cnt_o + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use/branch/memory-wait stall sequencer with memory-timeout watchdog
// HAZARD_CTRL_PERF_CNT_EN builds the three saturating performance counters; otherwise they read 0.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_RegRt_i,
    input  logic [4:0]       IF_ID_RegRs_i,
    input  logic [4:0]       IF_ID_RegRt_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             IF_ID_write_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_bubble_o,
    output logic             pipe_stall_o,
    output logic             err_o,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    hc_state_t        state;
    hc_state_t        stateNext;
    logic [TMO_W-1:0] tmoCnt;
    logic             luHit;
    logic             memWait;
    hc_cond_t         cond;

    assign luHit   = ID_EX_MemRead_i && (ID_EX_RegRt_i != 5'd0) &&
                     ((ID_EX_RegRt_i == IF_ID_RegRs_i) || (ID_EX_RegRt_i == IF_ID_RegRt_i));
    assign memWait = dmem_req_i && !dmem_ack_i;
    assign cond    = hcArbitrate(memWait, luHit, branch_taken_i);

    always_comb begin
        pc_write_o     = 1'b0;
        IF_ID_write_o  = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_bubble_o = 1'b0;
        pipe_stall_o   = 1'b0;
        stateNext      = state;
        if (!rst_n_i) begin
            IF_ID_flush_o  = 1'b1;
            ID_EX_bubble_o = 1'b1;
        end else if (state == ERR) begin
            pipe_stall_o = 1'b1;
        end else if ((state == MEM_WAIT) && !dmem_ack_i) begin
            pipe_stall_o = 1'b1;
            stateNext    = (tmoCnt == TMO_LAST) ? ERR : MEM_WAIT;
        end else begin
            // An ack in MEM_WAIT releases the freeze the same cycle and falls through to RUN arbitration.
            stateNext = RUN;
            case (cond)
                COND_MW: begin
                    pipe_stall_o = 1'b1;
                    stateNext    = MEM_WAIT;
                end
                COND_LU: ID_EX_bubble_o = 1'b1;
                COND_BR: begin
                    pc_write_o    = 1'b1;
                    IF_ID_write_o = 1'b1;
                    IF_ID_flush_o = 1'b1;
                end
                default: begin
                    pc_write_o    = 1'b1;
                    IF_ID_write_o = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= RUN;
            tmoCnt <= '0;
            err_o  <= 1'b0;
        end else begin
            state <= stateNext;
            err_o <= err_o || (stateNext == ERR);
            // Held at zero outside MEM_WAIT, so every entry starts a fresh count.
            if (state != MEM_WAIT)
                tmoCnt <= '0;
            else if (!dmem_ack_i)
                tmoCnt <= tmoCnt + 1'b1;
        end
    end

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic luInc;
    logic memInc;
    logic flushInc;

    assign luInc    = rst_n_i && ID_EX_bubble_o;
    assign memInc   = pipe_stall_o && (state != ERR);
    assign flushInc = rst_n_i && IF_ID_flush_o;

    hc_sat_counter #(.CNT_W(CNT_W)) uLuCnt (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(luInc), .cnt_o(lu_stall_cnt_o)
    );
    hc_sat_counter #(.CNT_W(CNT_W)) uMemCnt (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(memInc), .cnt_o(mem_stall_cnt_o)
    );
    hc_sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .inc_i(flushInc), .cnt_o(flush_cnt_o)
    );
`else
    assign lu_stall_cnt_o  = '0;
    assign mem_stall_cnt_o = '0;
    assign flush_cnt_o     = '0;
`endif

endmodule
